// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the alu_issue slice.
//   * FSM state type and state encodings for the issue controller
//   * MIPS opcode (bits 31:26) and R-type funct (bits 5:0) constants
//   * instruction field extraction helpers
package mips_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_EXEC = 2'd1;
    localparam state_t S_WB   = 2'd2;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    function automatic logic [5:0] op_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile -- 32 x 32-bit register file, r0 hardwired to zero.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset (clears all entries)
//   ra1_i/rd1_o, ra2_i/rd2_o two combinational read ports
//   we_i, wa_i, wd_i         single write port (writes to r0 are dropped)
//   dbg_raddr_i/dbg_rdata_o  combinational debug read port
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  ra1_i,
    output logic [31:0] rd1_o,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    input  logic [4:0]  dbg_raddr_i,
    output logic [31:0] dbg_rdata_o
);

    // r0 has no storage; entries 1..31 only
    logic [31:0] regs_q [1:31];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 1; i < 32; i++) begin
                regs_q[i[4:0]] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o       = (ra1_i == 5'd0)       ? '0 : regs_q[ra1_i];
    assign rd2_o       = (ra2_i == 5'd0)       ? '0 : regs_q[ra2_i];
    assign dbg_rdata_o = (dbg_raddr_i == 5'd0) ? '0 : regs_q[dbg_raddr_i];

endmodule

// File: rtl/alu_issue.sv
// alu_issue -- three-state (IDLE/EXEC/WB) issue controller between an
// instruction source, an external MIPS ALU and a 32-entry register file.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_valid/in_ready/in_instr        instruction handshake (ready only in IDLE)
//   alu_instr/alu_gr1/alu_gr2         latched instruction and rs/rt operands
//   alu_c/alu_hi/alu_lo               ALU result, HI and LO, sampled at end of EXEC
//   alu_zero/alu_negative/alu_overflow ALU flags, sampled at end of EXEC
//   wb_valid/wb_addr/wb_data          one-cycle register-write pulse during WB
//   branch_taken, exc                 one-cycle pulses during WB
//   dbg_raddr/dbg_rdata               combinational register-file observation
// Build option: define ALU_ISSUE_HILO_EN to add HI/LO registers loaded by
// mult/multu/div/divu and read by mfhi/mflo; otherwise mfhi/mflo raise exc.
module alu_issue
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [31:0] alu_instr,
    output logic [31:0] alu_gr1,
    output logic [31:0] alu_gr2,
    input  logic [31:0] alu_c,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        branch_taken,
    output logic        exc,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);

    state_t      state_q, state_d;
    logic [31:0] alu_instr_q, alu_gr1_q, alu_gr2_q;
    logic        wb_valid_q, branch_q, exc_q;
    logic [4:0]  wb_addr_q;
    logic [31:0] wb_data_q;
    logic [31:0] rf_rd1, rf_rd2;
    logic        accept;

    // decode results for the instruction in EXEC
    logic        wr_d, br_d, exc_d, hilo_ld_d;
    logic [4:0]  dst_d;
    logic [31:0] data_d;

`ifdef ALU_ISSUE_HILO_EN
    logic [31:0] hi_q, lo_q, res_hi_q, res_lo_q;
    logic        hilo_ld_q;
    logic        unused_inputs;
    assign unused_inputs = alu_negative;
`else
    logic        unused_inputs;
    assign unused_inputs = ^{alu_negative, alu_hi, alu_lo, hilo_ld_d};
`endif

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_d      = 1'b0;
        br_d      = 1'b0;
        exc_d     = 1'b0;
        hilo_ld_d = 1'b0;
        dst_d     = alu_instr_q[15:11];
        data_d    = alu_c;
        case (op_of(alu_instr_q))
            OP_RTYPE: begin
                case (funct_of(alu_instr_q))
                    F_ADD, F_SUB: begin
                        exc_d = alu_overflow;
                        wr_d  = !alu_overflow;
                    end
                    F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV:
                        wr_d = 1'b1;
                    F_MULT, F_MULTU, F_DIV, F_DIVU:
                        hilo_ld_d = 1'b1;
`ifdef ALU_ISSUE_HILO_EN
                    F_MFHI: begin
                        wr_d   = 1'b1;
                        data_d = hi_q;
                    end
                    F_MFLO: begin
                        wr_d   = 1'b1;
                        data_d = lo_q;
                    end
`endif
                    default: exc_d = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dst_d = alu_instr_q[20:16];
                exc_d = alu_overflow;
                wr_d  = !alu_overflow;
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                dst_d = alu_instr_q[20:16];
                wr_d  = 1'b1;
            end
            OP_BEQ:  br_d = alu_zero;
            OP_BNE:  br_d = !alu_zero;
            OP_LW, OP_SW: ;
            default: exc_d = 1'b1;
        endcase
    end

    // Pulse registers are loaded only at the end of EXEC and cleared at every
    // other edge, so they are high for exactly the WB cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            alu_instr_q <= '0;
            alu_gr1_q   <= '0;
            alu_gr2_q   <= '0;
            wb_valid_q  <= 1'b0;
            branch_q    <= 1'b0;
            exc_q       <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= (state_q == S_EXEC) && wr_d && (dst_d != 5'd0);
            branch_q   <= (state_q == S_EXEC) && br_d;
            exc_q      <= (state_q == S_EXEC) && exc_d;
            if (accept) begin
                alu_instr_q <= in_instr;
                alu_gr1_q   <= rf_rd1;
                alu_gr2_q   <= rf_rd2;
            end
            if (state_q == S_EXEC) begin
                wb_addr_q <= dst_d;
                wb_data_q <= data_d;
            end
        end
    end

`ifdef ALU_ISSUE_HILO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q      <= '0;
            lo_q      <= '0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
            hilo_ld_q <= 1'b0;
        end else begin
            hilo_ld_q <= (state_q == S_EXEC) && hilo_ld_d;
            if (state_q == S_EXEC) begin
                res_hi_q <= alu_hi;
                res_lo_q <= alu_lo;
            end
            if ((state_q == S_WB) && hilo_ld_q) begin
                hi_q <= res_hi_q;
                lo_q <= res_lo_q;
            end
        end
    end
`endif

    mips_regfile u_regfile (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .ra1_i       (in_instr[25:21]),
        .rd1_o       (rf_rd1),
        .ra2_i       (in_instr[20:16]),
        .rd2_o       (rf_rd2),
        .we_i        (wb_valid_q),
        .wa_i        (wb_addr_q),
        .wd_i        (wb_data_q),
        .dbg_raddr_i (dbg_raddr),
        .dbg_rdata_o (dbg_rdata)
    );

    assign alu_instr    = alu_instr_q;
    assign alu_gr1      = alu_gr1_q;
    assign alu_gr2      = alu_gr2_q;
    assign wb_valid     = wb_valid_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign branch_taken = branch_q;
    assign exc          = exc_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue -- scoreboard bench for alu_issue. The bench plays the ALU:
// it drives alu_c/hi/lo/flags with each instruction and holds them until the
// next one. Expected responses are queued at issue; a monitor checks EXEC
// (operands) and WB (pulses) as the DUT steps through its states.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] alu_instr, alu_gr1, alu_gr2;
    logic [31:0] alu_c, alu_hi, alu_lo;
    logic        alu_zero, alu_negative, alu_overflow;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        branch_taken, exc;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .alu_instr    (alu_instr),
        .alu_gr1      (alu_gr1),
        .alu_gr2      (alu_gr2),
        .alu_c        (alu_c),
        .alu_hi       (alu_hi),
        .alu_lo       (alu_lo),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .branch_taken (branch_taken),
        .exc          (exc),
        .dbg_raddr    (dbg_raddr),
        .dbg_rdata    (dbg_rdata)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] gr1;
        logic [31:0] gr2;
        logic [31:0] wb;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] br;
        logic [31:0] exc;
    } exp_t;

    exp_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, gr1, gr2,
                                input logic wb, input logic [4:0] addr,
                                input logic [31:0] data, input logic br, ex);
        exp_t e;
        e.instr = instr; e.gr1 = gr1; e.gr2 = gr2;
        e.wb = 32'(wb); e.addr = 32'(addr); e.data = data;
        e.br = 32'(br); e.exc = 32'(ex);
        return e;
    endfunction

    // Returns at a negedge where in_ready is high, or records a timeout.
    task automatic wait_ready();
        int unsigned k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_ready: in_ready=%0b after %0d cycles, expected 1", in_ready, k);
        end
    endtask

    task automatic issue(input logic [31:0] instr, c, hi, lo,
                         input logic z, ovf, input exp_t e, input bit hold);
        wait_ready();
        in_instr     = instr;
        alu_c        = c;
        alu_hi       = hi;
        alu_lo       = lo;
        alu_zero     = z;
        alu_overflow = ovf;
        in_valid     = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (hold) begin
            // keep offering a different word while busy; it must be ignored
            in_instr = 32'hFFFF_FFFF;
            wait_ready();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned k = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !in_ready) && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0 || !in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d responses outstanding, in_ready=%0b", sb.size(), in_ready);
        end
    endtask

    task automatic dbg(input logic [4:0] a, input logic [31:0] v, input string name);
        dbg_raddr = a;
        #1;
        check(name, dbg_rdata, v);
    endtask

    // Monitor: EXEC is recognised by in_ready falling; the next negedge is WB.
    initial begin
        bit   prev_rdy = 1'b0;
        bit   pend     = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                pend = 1'b0;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wb_unexpected: got response with empty scoreboard, expected none");
                end else begin
                    e = sb.pop_front();
                    check("wb_in_ready", 32'(in_ready), 32'd0);
                    check("wb_alu_instr_hold", alu_instr, e.instr);
                    check("wb_valid", 32'(wb_valid), e.wb);
                    check("wb_branch_taken", 32'(branch_taken), e.br);
                    check("wb_exc", 32'(exc), e.exc);
                    if (e.wb != 0) begin
                        check("wb_addr", 32'(wb_addr), e.addr);
                        check("wb_data", wb_data, e.data);
                    end
                end
            end else if (prev_rdy && !in_ready) begin
                pend = 1'b1;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL exec_unexpected: got EXEC with empty scoreboard, expected none");
                end else begin
                    e = sb[0];
                    check("exec_alu_instr", alu_instr, e.instr);
                    check("exec_alu_gr1", alu_gr1, e.gr1);
                    check("exec_alu_gr2", alu_gr2, e.gr2);
                    check("exec_pulses", 32'({wb_valid, branch_taken, exc}), 32'd0);
                end
            end else begin
                check("idle_pulses", 32'({wb_valid, branch_taken, exc}), 32'd0);
            end
            prev_rdy = in_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_instr     = '0;
        alu_c        = '0;
        alu_hi       = '0;
        alu_lo       = '0;
        alu_zero     = 1'b0;
        alu_negative = 1'b0;
        alu_overflow = 1'b0;
        dbg_raddr    = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_pulses", 32'({wb_valid, branch_taken, exc}), 32'd0);
        check("rst_alu_instr", alu_instr, 32'd0);
        check("rst_alu_gr1", alu_gr1, 32'd0);
        check("rst_alu_gr2", alu_gr2, 32'd0);
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        dbg(5'd1, 32'd0, "rst_rf1");
        rst_n = 1'b1;

        // addi r1,r0,5 ; add r2,r1,r1 (source holds a different word while busy)
        issue(32'h2001_0005, 32'd5, '0, '0, 1'b0, 1'b0,
              mk(32'h2001_0005, 32'd0, 32'd0, 1'b1, 5'd1, 32'd5, 1'b0, 1'b0), 1'b0);
        issue(32'h0021_1020, 32'h0000_000A, '0, '0, 1'b0, 1'b0,
              mk(32'h0021_1020, 32'd5, 32'd5, 1'b1, 5'd2, 32'h0000_000A, 1'b0, 1'b0), 1'b1);
        drain();
        dbg(5'd2, 32'h0000_000A, "rf2_after_add");
        dbg(5'd1, 32'd5, "rf1_after_addi");

        // load r1 with 0x7FFFFFFF via the ALU result, then overflowing add r3,r1,r1
        issue(32'h2401_7FFF, 32'h7FFF_FFFF, '0, '0, 1'b0, 1'b0,
              mk(32'h2401_7FFF, 32'd0, 32'd5, 1'b1, 5'd1, 32'h7FFF_FFFF, 1'b0, 1'b0), 1'b0);
        issue(32'h0021_1820, 32'hFFFF_FFFE, '0, '0, 1'b0, 1'b1,
              mk(32'h0021_1820, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1), 1'b0);
        drain();
        dbg(5'd3, 32'd0, "rf3_after_overflow");

        // r1=r2=7 ; beq taken ; bne not taken ; bne taken
        issue(32'h2401_0007, 32'd7, '0, '0, 1'b0, 1'b0,
              mk(32'h2401_0007, 32'd0, 32'h7FFF_FFFF, 1'b1, 5'd1, 32'd7, 1'b0, 1'b0), 1'b0);
        issue(32'h2402_0007, 32'd7, '0, '0, 1'b0, 1'b0,
              mk(32'h2402_0007, 32'd0, 32'h0000_000A, 1'b1, 5'd2, 32'd7, 1'b0, 1'b0), 1'b0);
        issue(32'h1022_0004, 32'd0, '0, '0, 1'b1, 1'b0,
              mk(32'h1022_0004, 32'd7, 32'd7, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0), 1'b0);
        issue(32'h1422_0004, 32'd0, '0, '0, 1'b1, 1'b0,
              mk(32'h1422_0004, 32'd7, 32'd7, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0), 1'b0);
        issue(32'h1422_0004, 32'd3, '0, '0, 1'b0, 1'b0,
              mk(32'h1422_0004, 32'd7, 32'd7, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0), 1'b0);

        // mult r1,r2 (HI=1, LO=2) ; mfhi r4 ; mflo r5 (alu_c carries junk)
        issue(32'h0022_0018, 32'h0000_0055, 32'd1, 32'd2, 1'b0, 1'b0,
              mk(32'h0022_0018, 32'd7, 32'd7, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0), 1'b0);
`ifdef ALU_ISSUE_HILO_EN
        issue(32'h0000_2010, 32'hDEAD_BEEF, 32'h0000_0BAD, 32'h0000_0BAD, 1'b0, 1'b0,
              mk(32'h0000_2010, 32'd0, 32'd0, 1'b1, 5'd4, 32'd1, 1'b0, 1'b0), 1'b0);
        issue(32'h0000_2812, 32'hDEAD_BEEF, 32'h0000_0BAD, 32'h0000_0BAD, 1'b0, 1'b0,
              mk(32'h0000_2812, 32'd0, 32'd0, 1'b1, 5'd5, 32'd2, 1'b0, 1'b0), 1'b0);
        drain();
        dbg(5'd4, 32'd1, "rf4_mfhi");
        dbg(5'd5, 32'd2, "rf5_mflo");
`else
        issue(32'h0000_2010, 32'hDEAD_BEEF, 32'h0000_0BAD, 32'h0000_0BAD, 1'b0, 1'b0,
              mk(32'h0000_2010, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1), 1'b0);
        issue(32'h0000_2812, 32'hDEAD_BEEF, 32'h0000_0BAD, 32'h0000_0BAD, 1'b0, 1'b0,
              mk(32'h0000_2812, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1), 1'b0);
        drain();
        dbg(5'd4, 32'd0, "rf4_mfhi_disabled");
        dbg(5'd5, 32'd0, "rf5_mflo_disabled");
`endif

        // addiu r0,r0,9 ; invalid opcode 0x3F ; lw r8,0(r1)
        issue(32'h2400_0009, 32'd9, '0, '0, 1'b0, 1'b0,
              mk(32'h2400_0009, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0), 1'b0);
        issue(32'hFC00_0000, 32'd1, '0, '0, 1'b0, 1'b0,
              mk(32'hFC00_0000, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1), 1'b0);
        issue(32'h8C28_0000, 32'h0000_1234, '0, '0, 1'b0, 1'b0,
              mk(32'h8C28_0000, 32'd7, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0), 1'b0);
        drain();
        dbg(5'd0, 32'd0, "rf0_zero");
        dbg(5'd8, 32'd0, "rf8_after_lw");

        // reset while addi r6,r0,3 is in EXEC
        wait_ready();
        in_instr     = 32'h2006_0003;
        alu_c        = 32'd3;
        alu_zero     = 1'b0;
        alu_overflow = 1'b0;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_alu_instr", alu_instr, 32'd0);
        check("midrst_pulses_1", 32'({wb_valid, branch_taken, exc}), 32'd0);
        @(negedge clk);
        check("midrst_pulses_2", 32'({wb_valid, branch_taken, exc}), 32'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_pulses_3", 32'({wb_valid, branch_taken, exc}), 32'd0);
        dbg(5'd6, 32'd0, "rf6_after_midrst");
        dbg(5'd1, 32'd0, "rf1_cleared_by_reset");

        // recovery after reset: addi r7,r0,1
        issue(32'h2007_0001, 32'd1, '0, '0, 1'b0, 1'b0,
              mk(32'h2007_0001, 32'd0, 32'd0, 1'b1, 5'd7, 32'd1, 1'b0, 1'b0), 1'b0);
        drain();
        dbg(5'd7, 32'd1, "rf7_after_recovery");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
